// File: rtl/wb_stage_multi_if.sv
// ---------------------------------------------------------------------------
// wb_stage_multi_if
//   Bundles the MEM/WB stage control, per-lane inputs and writeback outputs
//   of wb_stage_multi. All per-lane fields are flat vectors with lane i in
//   slice [i*W +: W].
//
//   Handshake: valid-only. A lane transfers on any clock edge where the stage
//   is not stalled and not flushed and its in_valid bit is set. There is no
//   ready: stall is the only backpressure, and it freezes every lane at once.
//
//   Modports
//     master : upstream pipeline / bench. Drives stall, flush and in_*.
//              Observes wb_* and retired.
//     slave  : the stage itself.
// ---------------------------------------------------------------------------
interface wb_stage_multi_if #(
  parameter int WIDTH = 64,
  parameter int LANES = 2,
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
);
  logic                   stall;
  logic                   flush;
  logic [LANES-1:0]       in_valid;
  logic [LANES-1:0]       in_reg_write;
  logic [LANES-1:0]       in_mem_to_reg;
  logic [2*LANES-1:0]     in_size;
  logic [LANES-1:0]       in_signed;
  logic [RA_W*LANES-1:0]  in_rd;
  logic [WIDTH*LANES-1:0] in_mem_data;
  logic [WIDTH*LANES-1:0] in_alu_result;

  logic [LANES-1:0]       wb_en;
  logic [RA_W*LANES-1:0]  wb_rd;
  logic [WIDTH*LANES-1:0] wb_data;
  logic [CNT_W-1:0]       retired;

  modport master (
    output stall, flush, in_valid, in_reg_write, in_mem_to_reg, in_size,
           in_signed, in_rd, in_mem_data, in_alu_result,
    input  wb_en, wb_rd, wb_data, retired
  );

  modport slave (
    input  stall, flush, in_valid, in_reg_write, in_mem_to_reg, in_size,
           in_signed, in_rd, in_mem_data, in_alu_result,
    output wb_en, wb_rd, wb_data, retired
  );
endinterface

// File: rtl/wb_stage_multi.sv
// ---------------------------------------------------------------------------
// wb_stage_multi
//   Multi-lane MEM/WB pipeline register plus writeback select.
//   Each lane latches memory-read data and the ALU result, picks one of them,
//   size/sign-extends loads and drives one register-file write port. When two
//   lanes target the same register, the higher (younger) lane wins. A wrapping
//   counter tracks retired instructions.
//
//   Ports
//     clk      : rising-edge clock
//     reset_n  : asynchronous active-low reset, clears every stage register
//     bus      : wb_stage_multi_if.slave
//                stall/flush, in_* per-lane inputs, wb_* per-lane outputs,
//                retired counter
//
//   Timing: one cycle of latency. Outputs depend only on the stage registers.
//   Edge priority: reset > flush > stall > load.
// ---------------------------------------------------------------------------
module wb_stage_multi #(
  parameter int WIDTH    = 64,
  parameter int LANES    = 2,
  parameter int RA_W     = 5,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  wb_stage_multi_if.slave  bus
);

  localparam logic [RA_W-1:0] ZERO_RD = RA_W'(ZERO_REG);

  // Stage registers
  logic [LANES-1:0]       valid_q;
  logic [LANES-1:0]       reg_write_q;
  logic [LANES-1:0]       mem_to_reg_q;
  logic [LANES-1:0]       signed_q;
  logic [2*LANES-1:0]     size_q;
  logic [RA_W*LANES-1:0]  rd_q;
  logic [WIDTH*LANES-1:0] mem_data_q;
  logic [WIDTH*LANES-1:0] alu_q;
  logic [CNT_W-1:0]       retired_q;

  // Combinational lane outputs
  logic [LANES-1:0]       en_w;
  logic [WIDTH*LANES-1:0] data_w;

  // Number of lanes presented this cycle
  logic [CNT_W-1:0]       in_count;

  // Data fields are allowed to move on a flush; only the valid bits and the
  // counter need to be protected. Loading them on flush keeps the enable term
  // simple.
  logic load_data;
  assign load_data = bus.flush | ~bus.stall;

  always_comb begin
    in_count = '0;
    for (int i = 0; i < LANES; i++) begin
      in_count = in_count + CNT_W'(bus.in_valid[i]);
    end
  end

  // Valid bits and retired counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= '0;
      retired_q <= '0;
    end else if (bus.flush) begin
      valid_q   <= '0;
    end else if (!bus.stall) begin
      valid_q   <= bus.in_valid;
      // Wraps modulo 2^CNT_W by natural overflow.
      retired_q <= retired_q + in_count;
    end
  end

  // Control and data fields
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_write_q  <= '0;
      mem_to_reg_q <= '0;
      signed_q     <= '0;
      size_q       <= '0;
      rd_q         <= '0;
      mem_data_q   <= '0;
      alu_q        <= '0;
    end else if (load_data) begin
      reg_write_q  <= bus.in_reg_write;
      mem_to_reg_q <= bus.in_mem_to_reg;
      signed_q     <= bus.in_signed;
      size_q       <= bus.in_size;
      rd_q         <= bus.in_rd;
      mem_data_q   <= bus.in_mem_data;
      alu_q        <= bus.in_alu_result;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [WIDTH-1:0] md;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] load_val;
    logic [RA_W-1:0]  my_rd;
    logic             sbit;
    logic             shadowed;

    assign md    = mem_data_q[g*WIDTH +: WIDTH];
    assign my_rd = rd_q[g*RA_W +: RA_W];

    // Load extraction: keep the low 8<<size bits, then fill the rest with
    // either the top kept bit (signed) or zeros. Mask form avoids
    // zero-width replications when WIDTH is 32.
    always_comb begin
      mask = '1;
      sbit = 1'b0;
      case (size_q[2*g +: 2])
        2'b00: begin
          mask = WIDTH'(8'hFF);
          sbit = md[7];
        end
        2'b01: begin
          mask = WIDTH'(16'hFFFF);
          sbit = md[15];
        end
        2'b10: begin
          mask = WIDTH'(32'hFFFF_FFFF);
          sbit = md[31];
        end
        default: begin
          mask = '1;
          sbit = 1'b0;
        end
      endcase
      load_val = (md & mask) | ((signed_q[g] & sbit) ? ~mask : '0);
    end

    // A younger lane writing the same register makes this lane's write dead.
    always_comb begin
      shadowed = 1'b0;
      for (int j = g + 1; j < LANES; j++) begin
        if (valid_q[j] && reg_write_q[j] && (rd_q[j*RA_W +: RA_W] == my_rd)) begin
          shadowed = 1'b1;
        end
      end
    end

    assign en_w[g] = valid_q[g] & reg_write_q[g] & (my_rd != ZERO_RD) & ~shadowed;
    assign data_w[g*WIDTH +: WIDTH] = mem_to_reg_q[g] ? load_val
                                                      : alu_q[g*WIDTH +: WIDTH];
  end

  assign bus.wb_en   = en_w;
  assign bus.wb_rd   = rd_q;
  assign bus.wb_data = data_w;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_wb_stage_multi.sv
// ---------------------------------------------------------------------------
// tb_wb_stage_multi
//   Self-checking bench for wb_stage_multi. A second instance with a 4-bit
//   counter shares the same inputs to exercise counter wrap.
//   Expected outputs are computed from the driven stimulus by a reference
//   model, pushed to exp_q before each edge, and popped/compared after it.
// ---------------------------------------------------------------------------
module tb_wb_stage_multi;
  localparam int WIDTH = 64;
  localparam int LANES = 2;
  localparam int RA_W  = 5;
  localparam int CNT_W = 32;
  localparam int E_W   = 1 + LANES + RA_W*LANES + WIDTH*LANES + CNT_W + 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  wb_stage_multi_if #(.WIDTH(WIDTH), .LANES(LANES), .RA_W(RA_W), .CNT_W(CNT_W)) bus ();
  wb_stage_multi_if #(.WIDTH(WIDTH), .LANES(LANES), .RA_W(RA_W), .CNT_W(4))     bus_c ();

  assign bus_c.stall         = bus.stall;
  assign bus_c.flush         = bus.flush;
  assign bus_c.in_valid      = bus.in_valid;
  assign bus_c.in_reg_write  = bus.in_reg_write;
  assign bus_c.in_mem_to_reg = bus.in_mem_to_reg;
  assign bus_c.in_size       = bus.in_size;
  assign bus_c.in_signed     = bus.in_signed;
  assign bus_c.in_rd         = bus.in_rd;
  assign bus_c.in_mem_data   = bus.in_mem_data;
  assign bus_c.in_alu_result = bus.in_alu_result;

  wb_stage_multi #(.WIDTH(WIDTH), .LANES(LANES), .RA_W(RA_W), .ZERO_REG(31), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  wb_stage_multi #(.WIDTH(WIDTH), .LANES(LANES), .RA_W(RA_W), .ZERO_REG(31), .CNT_W(4)) dut_c (
    .clk(clk), .reset_n(reset_n), .bus(bus_c)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [E_W-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state (outputs as they should appear after the edge)
  logic             m_valid [LANES];
  logic             m_rw    [LANES];
  logic [RA_W-1:0]  m_rd    [LANES];
  logic [WIDTH-1:0] m_data  [LANES];
  logic             m_known;
  logic [CNT_W-1:0] m_ret;
  logic [3:0]       m_ret4;

  function automatic logic [63:0] ref_data(input logic m2r, input logic [1:0] sz,
                                           input logic sg, input logic [63:0] md,
                                           input logic [63:0] alu);
    if (!m2r) return alu;
    case (sz)
      2'b00:   return sg ? {{56{md[7]}},  md[7:0]}  : {56'd0, md[7:0]};
      2'b01:   return sg ? {{48{md[15]}}, md[15:0]} : {48'd0, md[15:0]};
      2'b10:   return sg ? {{32{md[31]}}, md[31:0]} : {32'd0, md[31:0]};
      default: return md;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) begin
      m_valid[i] = 1'b0;
      m_rw[i]    = 1'b0;
      m_rd[i]    = '0;
      m_data[i]  = '0;
    end
    m_known = 1'b1;
    m_ret   = '0;
    m_ret4  = '0;
  endtask

  function automatic logic [LANES-1:0] model_en();
    logic [LANES-1:0] en;
    for (int i = 0; i < LANES; i++) begin
      logic sh;
      sh = 1'b0;
      for (int j = i + 1; j < LANES; j++)
        if (m_valid[j] && m_rw[j] && m_rd[j] == m_rd[i]) sh = 1'b1;
      en[i] = m_valid[i] && m_rw[i] && (m_rd[i] != 5'd31) && !sh;
    end
    return en;
  endfunction

  // Advance the model by one edge using the currently driven inputs and
  // push the resulting expected outputs.
  task automatic model_edge();
    int cnt;
    if (bus.flush || !bus.stall) begin
      for (int i = 0; i < LANES; i++) begin
        m_rw[i]   = bus.in_reg_write[i];
        m_rd[i]   = bus.in_rd[i*RA_W +: RA_W];
        m_data[i] = ref_data(bus.in_mem_to_reg[i], bus.in_size[2*i +: 2], bus.in_signed[i],
                             bus.in_mem_data[i*WIDTH +: WIDTH],
                             bus.in_alu_result[i*WIDTH +: WIDTH]);
      end
    end
    if (bus.flush) begin
      for (int i = 0; i < LANES; i++) m_valid[i] = 1'b0;
      m_known = 1'b0;
    end else if (!bus.stall) begin
      cnt = 0;
      for (int i = 0; i < LANES; i++) begin
        m_valid[i] = bus.in_valid[i];
        cnt += int'(bus.in_valid[i]);
      end
      m_known = 1'b1;
      m_ret   = m_ret + CNT_W'(cnt);
      m_ret4  = m_ret4 + 4'(cnt);
    end
    exp_q.push_back({m_known, model_en(), m_rd[1], m_rd[0], m_data[1], m_data[0], m_ret, m_ret4});
  endtask

  task automatic compare_out();
    logic [E_W-1:0] e;
    if (exp_q.size() == 0) begin
      check_val("exp_q_empty", 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    check_val("wb_en",     64'(bus.wb_en),   64'(e[175:174]));
    check_val("retired",   64'(bus.retired), 64'(e[35:4]));
    check_val("retired_c", 64'(bus_c.retired), 64'(e[3:0]));
    if (e[176]) begin
      check_val("wb_rd0",   64'(bus.wb_rd[4:0]),   64'(e[168:164]));
      check_val("wb_rd1",   64'(bus.wb_rd[9:5]),   64'(e[173:169]));
      check_val("wb_data0", bus.wb_data[63:0],     e[99:36]);
      check_val("wb_data1", bus.wb_data[127:64],   e[163:100]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid = '0;
    bus.in_reg_write = '0;
    bus.in_mem_to_reg = '0;
    bus.in_size = '0;
    bus.in_signed = '0;
    bus.in_rd = '0;
    bus.in_mem_data = '0;
    bus.in_alu_result = '0;
  endtask

  task automatic set_lane(input int l, input logic v, input logic rw, input logic m2r,
                          input logic [1:0] sz, input logic sg, input logic [4:0] rd,
                          input logic [63:0] md, input logic [63:0] alu);
    bus.in_valid[l]              = v;
    bus.in_reg_write[l]          = rw;
    bus.in_mem_to_reg[l]         = m2r;
    bus.in_size[2*l +: 2]        = sz;
    bus.in_signed[l]             = sg;
    bus.in_rd[l*RA_W +: RA_W]    = rd;
    bus.in_mem_data[l*WIDTH +: WIDTH]   = md;
    bus.in_alu_result[l*WIDTH +: WIDTH] = alu;
  endtask

  task automatic random_lane(input int l);
    set_lane(l, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(28, 31)),
             {$urandom(), $urandom()}, {$urandom(), $urandom()});
  endtask

  // One clock edge: push expectation, wait for edge, compare just after it.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_en"},   64'(bus.wb_en),   64'd0);
    check_val({tag, "_rd"},   64'(bus.wb_rd),   64'd0);
    check_val({tag, "_d0"},   bus.wb_data[63:0],   64'd0);
    check_val({tag, "_d1"},   bus.wb_data[127:64], 64'd0);
    check_val({tag, "_ret"},  64'(bus.retired), 64'd0);
    check_val({tag, "_retc"}, 64'(bus_c.retired), 64'd0);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    clear_inputs();
    model_reset();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  // ---------------- stimulus ----------------
  localparam logic [63:0] LD_MD = 64'hFFFF_FFFF_8000_80F0;
  logic [1:0]  ld_sz  [5] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11};
  logic        ld_sg  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [63:0] ld_exp [5] = '{64'hFFFF_FFFF_FFFF_FFF0, 64'h0000_0000_0000_00F0,
                              64'hFFFF_FFFF_FFFF_80F0, 64'h0000_0000_8000_80F0,
                              64'hFFFF_FFFF_8000_80F0};

  initial begin
    logic [CNT_W-1:0] ret_hold;
    logic [LANES-1:0] en_hold;

    clear_inputs();
    apply_reset();

    // ALU writeback on lane 0, then XZR suppression
    set_lane(0, 1, 1, 0, 2'b00, 0, 5'd3, 64'd0, 64'h1234);
    step();
    check_val("alu_en",   64'(bus.wb_en), 64'b01);
    check_val("alu_rd",   64'(bus.wb_rd[4:0]), 64'd3);
    check_val("alu_data", bus.wb_data[63:0], 64'h1234);
    set_lane(0, 1, 1, 0, 2'b00, 0, 5'd31, 64'd0, 64'h1234);
    step();
    check_val("xzr_en", 64'(bus.wb_en), 64'b00);

    // Load extension table
    for (int k = 0; k < 5; k++) begin
      set_lane(0, 1, 1, 1, ld_sz[k], ld_sg[k], 5'd5, LD_MD, 64'hDEAD);
      step();
      check_val($sformatf("load%0d", k), bus.wb_data[63:0], ld_exp[k]);
    end

    // Same-destination arbitration
    set_lane(0, 1, 1, 0, 2'b00, 0, 5'd7, 64'd0, 64'hAAAA);
    set_lane(1, 1, 1, 0, 2'b00, 0, 5'd7, 64'd0, 64'hBBBB);
    step();
    check_val("arb_en",    64'(bus.wb_en), 64'b10);
    check_val("arb_data1", bus.wb_data[127:64], 64'hBBBB);
    set_lane(1, 1, 0, 0, 2'b00, 0, 5'd7, 64'd0, 64'hBBBB);
    step();
    check_val("arb_en_rw0", 64'(bus.wb_en), 64'b01);

    // Stall holds everything, flush beats stall
    set_lane(0, 1, 1, 0, 2'b00, 0, 5'd1, 64'd0, 64'h1111);
    set_lane(1, 1, 1, 0, 2'b00, 0, 5'd2, 64'd0, 64'h2222);
    step();
    ret_hold = bus.retired;
    en_hold  = bus.wb_en;
    check_val("pair_en", 64'(en_hold), 64'b11);
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      random_lane(0);
      random_lane(1);
      step();
      check_val("stall_ret",   64'(bus.retired), 64'(ret_hold));
      check_val("stall_en",    64'(bus.wb_en), 64'(en_hold));
      check_val("stall_data0", bus.wb_data[63:0], 64'h1111);
    end
    bus.flush = 1'b1;
    step();
    check_val("flush_en",  64'(bus.wb_en), 64'b00);
    check_val("flush_ret", 64'(bus.retired), 64'(ret_hold));
    bus.flush = 1'b0;
    bus.stall = 1'b0;

    // Randomised traffic with occasional stall/flush
    for (int k = 0; k < 200; k++) begin
      random_lane(0);
      random_lane(1);
      bus.stall = ($urandom_range(0, 9) == 0);
      bus.flush = ($urandom_range(0, 19) == 0);
      step();
    end
    bus.stall = 1'b0;
    bus.flush = 1'b0;

    // Asynchronous reset between edges
    set_lane(0, 1, 1, 0, 2'b00, 0, 5'd9, 64'd0, 64'h9999);
    set_lane(1, 1, 1, 0, 2'b00, 0, 5'd10, 64'd0, 64'hAAAA);
    step();
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    #1;

    // Counter wrap on the 4-bit instance: 9 edges x 2 lanes = 18 -> 2
    clear_inputs();
    set_lane(0, 1, 1, 0, 2'b00, 0, 5'd4, 64'd0, 64'h4);
    set_lane(1, 1, 1, 0, 2'b00, 0, 5'd6, 64'd0, 64'h6);
    for (int k = 0; k < 9; k++) step();
    check_val("cnt_wrap4",  64'(bus_c.retired), 64'd2);
    check_val("cnt_full32", 64'(bus.retired), 64'd18);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
